sha256_padder: RTL and testbench
================================

SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 The block SHALL have no parameters; all widths SHALL come from sha256_pkg.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  message word offered.
REQ-005 in_ready  output  1  padder accepts the word this cycle.
REQ-006 in_data  input  32  message word, big-endian; byte 0 is in_data[31:24].
REQ-007 in_last  input  1  final word of the message.
REQ-008 in_bytes  input  3  valid bytes when in_last=1, range 0..4; values 5..7 are treated as 4; ignored when in_last=0.
REQ-009 blk_valid  output  1  padded 512-bit block available.
REQ-010 blk_ready  input  1  hash core consumes the block.
REQ-011 blk_data  output  512  block; word 0 is blk_data[511:480].
REQ-012 blk_last  output  1  block is the final block of the message.

Function
REQ-013 Input transfer SHALL occur on in_valid&&in_ready; output transfer SHALL occur on blk_valid&&blk_ready.
REQ-014 FSM states SHALL be S_FILL, S_EMIT, S_EMIT_PAD, S_EXTRA and S_FINAL; in_ready=1 only in S_FILL; blk_valid=1 only in S_EMIT, S_EMIT_PAD and S_FINAL.
REQ-015 A 4-bit word counter wc (0..15) and a 64-bit bit-length counter len SHALL be kept; len wraps modulo 2^64.
REQ-016 Non-last transfer: write in_data to word wc, len+=32, wc+=1; if wc was 15, go to S_EMIT the next cycle.
REQ-017 Last transfer with n=in_bytes: keep bytes 0..n-1 of in_data, write 0x80 at byte n, zero the following bytes, len+=8n; if n=4, 0x80 goes to byte 0 of word wc+1.
REQ-018 Let p be the word index holding 0x80; all words after p SHALL be zero.
REQ-019 If p<=13: words 14..15 = final len (word 14 = len[63:32]); go to S_FINAL.
REQ-020 If p>=14: go to S_EMIT_PAD.
REQ-021 In S_EMIT_PAD, blk_last=0; on transfer go to S_EXTRA.
REQ-022 S_EXTRA lasts one cycle and builds an all-zero block with word 0 = 0x80000000 only if p=16, and words 14..15 = len; it then goes to S_FINAL.
REQ-023 S_EMIT transfer: clear the buffer, wc=0, return to S_FILL with len kept; blk_last=0.
REQ-024 S_FINAL: blk_last=1; on transfer, clear the buffer, wc=0, len=0, return to S_FILL.
REQ-025 blk_valid SHALL rise the cycle after the triggering input transfer.
REQ-026 blk_data and blk_last SHALL be held stable while blk_valid=1 and blk_ready=0.
REQ-027 blk_data SHALL be registered; it SHALL have no combinational path from in_* or blk_ready.
REQ-028 An empty message (in_last=1, in_bytes=0 at wc=0) SHALL produce one block: word 0 = 0x80000000, remaining words zero.

Reset
REQ-029 While reset=1 at a clock edge: state=S_FILL, wc=0, len=0, buffer=0.
REQ-030 Output reset values: in_ready=1 the cycle after reset; blk_valid=0, blk_last=0, blk_data=0.
REQ-031 Reset mid-message or mid-emit SHALL discard all partial data, with no further block for that message.

Structure
REQ-032 sha256_pkg SHALL hold BLOCK_BITS=512, WORD_BITS=32, LEN_BITS=64, PAD_BYTE=8'h80 and the padder state enum type.
REQ-033 One combinational sub-module, sha256_pad_word, SHALL do byte masking and 0x80 insertion for a single word given n.

Verification
REQ-034 "abc": in_data=0x61626300, in_bytes=3, last at wc=0 -> one block, word0=0x61626380, words1..14=0, word15=0x00000018, blk_last=1.
REQ-035 Empty message: in_bytes=0, last -> word0=0x80000000, all other words 0, blk_last=1.
REQ-036 56 bytes (14 full words, last with in_bytes=4) -> block 1: words 0..13 data, word14=0x80000000, word15=0, blk_last=0; block 2: zeros with word15=0x000001C0, blk_last=1.
REQ-037 64 bytes (16 full words) -> block 1: data only, blk_last=0; block 2: word0=0x80000000, word15=0x00000200, blk_last=1.
REQ-038 Backpressure: hold blk_ready=0 for 5 cycles -> blk_valid=1 and blk_data constant, in_ready=0 throughout; one transfer when blk_ready=1.
REQ-039 Assert reset after 7 words, then send "abc" -> the single block matches REQ-034 exactly.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared widths, constants and the padder state type for the SHA-256 message padder.
package sha256_pkg;
  localparam int BLOCK_BITS = 512;
  localparam int WORD_BITS  = 32;
  localparam int LEN_BITS   = 64;
  localparam int WORDS      = BLOCK_BITS / WORD_BITS;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [2:0] {
    S_FILL,
    S_EMIT,
    S_EMIT_PAD,
    S_EXTRA,
    S_FINAL
  } pad_state_e;

  // Byte counts above 4 mean a full word.
  function automatic logic [2:0] sat_bytes(input logic [2:0] n);
    return (n > 3'd4) ? 3'd4 : n;
  endfunction
endpackage

// File: rtl/sha256_pad_word.sv
// Combinational per-word padding: keeps bytes 0..n-1, puts the pad byte at
// byte n and zeroes the bytes after it. n=4 passes the word through unchanged.
//   word_i : big-endian message word (byte 0 = word_i[31:24])
//   n_i    : number of valid bytes, 0..4
//   word_o : padded word
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [WORD_BITS-1:0] word_i,
  input  logic [2:0]           n_i,
  output logic [WORD_BITS-1:0] word_o
);
  logic [0:3][7:0] bytes_in, bytes_out;

  assign bytes_in = word_i;
  assign word_o   = bytes_out;

  always_comb begin
    bytes_out = '0;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < n_i)       bytes_out[2'(b)] = bytes_in[2'(b)];
      else if (3'(b) == n_i) bytes_out[2'(b)] = PAD_BYTE;
    end
  end
endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit message words into 512-bit blocks,
// appends the 0x80 marker, zero fill and 64-bit bit length, and emits one
// or two final blocks depending on where the marker lands.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : message word handshake (in_data, in_last, in_bytes)
//   blk_valid/blk_ready   : block handshake (blk_data, blk_last)
module sha256_padder
  import sha256_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_BITS-1:0]  in_data,
  input  logic                  in_last,
  input  logic [2:0]            in_bytes,
  output logic                  blk_valid,
  input  logic                  blk_ready,
  output logic [BLOCK_BITS-1:0] blk_data,
  output logic                  blk_last
);
  pad_state_e                      state_q, state_d;
  logic [0:WORDS-1][WORD_BITS-1:0] blk_q, blk_d;
  logic [3:0]                      wc_q, wc_d;
  logic [LEN_BITS-1:0]             len_q, len_d;
  logic                            pad16_q, pad16_d; // marker spilled into the extra block

  logic [2:0]           n_eff;
  logic [WORD_BITS-1:0] pad_word;
  logic [4:0]           p;        // word index of the 0x80 marker (16 = next block)
  logic [LEN_BITS-1:0]  len_last;

  assign n_eff    = sat_bytes(in_bytes);
  assign p        = (n_eff == 3'd4) ? {1'b0, wc_q} + 5'd1 : {1'b0, wc_q};
  assign len_last = len_q + LEN_BITS'({n_eff, 3'b000});

  sha256_pad_word u_pad (
    .word_i (in_data),
    .n_i    (n_eff),
    .word_o (pad_word)
  );

  // Outputs are straight from registers; blk_data never sees in_* or blk_ready.
  assign in_ready  = (state_q == S_FILL);
  assign blk_valid = (state_q == S_EMIT) || (state_q == S_EMIT_PAD) || (state_q == S_FINAL);
  assign blk_last  = (state_q == S_FINAL);
  assign blk_data  = blk_q;

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    wc_d    = wc_q;
    len_d   = len_q;
    pad16_d = pad16_q;
    case (state_q)
      S_FILL: if (in_valid) begin
        if (!in_last) begin
          blk_d[wc_q] = in_data;
          len_d       = len_q + 64'd32;
          wc_d        = wc_q + 4'd1;
          if (wc_q == 4'd15) state_d = S_EMIT;
        end else begin
          blk_d[wc_q] = pad_word;
          len_d       = len_last;
          wc_d        = '0;
          pad16_d     = (p == 5'd16);
          // A full last word pushes the marker into the following word.
          if (n_eff == 3'd4 && wc_q != 4'd15) blk_d[wc_q + 4'd1] = {PAD_BYTE, 24'h0};
          if (p <= 5'd13) begin
            blk_d[14] = len_last[63:32];
            blk_d[15] = len_last[31:0];
            state_d   = S_FINAL;
          end else begin
            state_d = S_EMIT_PAD;
          end
        end
      end
      S_EMIT: if (blk_ready) begin
        blk_d   = '0;
        wc_d    = '0;
        state_d = S_FILL;
      end
      S_EMIT_PAD: if (blk_ready) state_d = S_EXTRA;
      S_EXTRA: begin
        blk_d = '0;
        if (pad16_q) blk_d[0] = {PAD_BYTE, 24'h0};
        blk_d[14] = len_q[63:32];
        blk_d[15] = len_q[31:0];
        state_d   = S_FINAL;
      end
      S_FINAL: if (blk_ready) begin
        blk_d   = '0;
        wc_d    = '0;
        len_d   = '0;
        pad16_d = 1'b0;
        state_d = S_FILL;
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FILL;
      blk_q   <= '0;
      wc_q    <= '0;
      len_q   <= '0;
      pad16_q <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      wc_q    <= wc_d;
      len_q   <= len_d;
      pad16_q <= pad16_d;
    end
  end
endmodule

// File: tb/tb_sha256_padder.sv
module tb_sha256_padder;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic [2:0]   in_bytes = '0;
  logic         blk_valid;
  logic         blk_ready = 1'b0;
  logic [511:0] blk_data;
  logic         blk_last;

  int n_cmp = 0;
  int n_bad = 0;

  sha256_padder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_last  (blk_last)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; blk_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int t = 0;
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    n_cmp++;
    if (!in_ready) begin n_bad++; $display("FAIL in_ready_timeout got %b want 1", in_ready); end
    in_valid = 1'b1; in_data = d; in_last = last; in_bytes = nb;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic get_block(output logic [511:0] d, output logic l);
    int t = 0;
    while (!blk_valid && t < 20) begin @(negedge clk); t++; end
    n_cmp++;
    if (!blk_valid) begin n_bad++; $display("FAIL blk_valid_timeout got %b want 1", blk_valid); end
    d = blk_data; l = blk_last;
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    n_cmp++; if (blk_valid !== 1'b0) begin n_bad++; $display("FAIL rst_blk_valid got %b want 0", blk_valid); end
    n_cmp++; if (blk_last !== 1'b0) begin n_bad++; $display("FAIL rst_blk_last got %b want 0", blk_last); end
    n_cmp++; if (blk_data !== 512'h0) begin n_bad++; $display("FAIL rst_blk_data got %h want 0", blk_data); end
  endtask

  task automatic check_abc(input string tag);
    logic [0:15][31:0] exp;
    logic [511:0] d; logic l;
    exp = '0; exp[0] = 32'h61626380; exp[15] = 32'h00000018;
    send(32'h61626300, 1'b1, 3'd3);
    n_cmp++; if (blk_valid !== 1'b1) begin n_bad++; $display("FAIL %s_latency got %b want 1", tag, blk_valid); end
    get_block(d, l);
    n_cmp++; if (d !== exp) begin n_bad++; $display("FAIL %s_data got %h want %h", tag, d, exp); end
    n_cmp++; if (l !== 1'b1) begin n_bad++; $display("FAIL %s_last got %b want 1", tag, l); end
    n_cmp++; if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s_after got valid=%b ready=%b want 0/1", tag, blk_valid, in_ready);
    end
  endtask

  task automatic test_abc();
    check_abc("abc");
  endtask

  task automatic test_empty();
    logic [0:15][31:0] exp;
    logic [511:0] d; logic l;
    exp = '0; exp[0] = 32'h80000000;
    send(32'hFFFFFFFF, 1'b1, 3'd0);
    get_block(d, l);
    n_cmp++; if (d !== exp) begin n_bad++; $display("FAIL empty_data got %h want %h", d, exp); end
    n_cmp++; if (l !== 1'b1) begin n_bad++; $display("FAIL empty_last got %b want 1", l); end
  endtask

  task automatic test_sat_bytes();
    logic [0:15][31:0] exp;
    logic [511:0] d; logic l;
    exp = '0; exp[0] = 32'hDEADBEEF; exp[1] = 32'h80000000; exp[15] = 32'h00000020;
    send(32'hDEADBEEF, 1'b1, 3'd7);
    get_block(d, l);
    n_cmp++; if (d !== exp) begin n_bad++; $display("FAIL sat7_data got %h want %h", d, exp); end
    n_cmp++; if (l !== 1'b1) begin n_bad++; $display("FAIL sat7_last got %b want 1", l); end
  endtask

  task automatic test_56_bytes();
    logic [0:15][31:0] exp1, exp2;
    logic [511:0] d; logic l;
    exp1 = '0; exp2 = '0;
    for (int i = 0; i < 14; i++) exp1[i] = 32'hA5000000 | 32'(i);
    exp1[14] = 32'h80000000;
    exp2[15] = 32'h000001C0;
    for (int i = 0; i < 14; i++) send(32'hA5000000 | 32'(i), (i == 13), 3'd4);
    get_block(d, l);
    n_cmp++; if (d !== exp1) begin n_bad++; $display("FAIL b56_blk1_data got %h want %h", d, exp1); end
    n_cmp++; if (l !== 1'b0) begin n_bad++; $display("FAIL b56_blk1_last got %b want 0", l); end
    n_cmp++; if (blk_valid !== 1'b0) begin n_bad++; $display("FAIL b56_extra_valid got %b want 0", blk_valid); end
    get_block(d, l);
    n_cmp++; if (d !== exp2) begin n_bad++; $display("FAIL b56_blk2_data got %h want %h", d, exp2); end
    n_cmp++; if (l !== 1'b1) begin n_bad++; $display("FAIL b56_blk2_last got %b want 1", l); end
  endtask

  task automatic test_64_bytes();
    logic [0:15][31:0] exp1, exp2;
    logic [511:0] d; logic l;
    exp2 = '0;
    for (int i = 0; i < 16; i++) exp1[i] = 32'h3C000000 | 32'(i * 3);
    exp2[0] = 32'h80000000; exp2[15] = 32'h00000200;
    for (int i = 0; i < 16; i++) send(32'h3C000000 | 32'(i * 3), (i == 15), 3'd4);
    get_block(d, l);
    n_cmp++; if (d !== exp1) begin n_bad++; $display("FAIL b64_blk1_data got %h want %h", d, exp1); end
    n_cmp++; if (l !== 1'b0) begin n_bad++; $display("FAIL b64_blk1_last got %b want 0", l); end
    get_block(d, l);
    n_cmp++; if (d !== exp2) begin n_bad++; $display("FAIL b64_blk2_data got %h want %h", d, exp2); end
    n_cmp++; if (l !== 1'b1) begin n_bad++; $display("FAIL b64_blk2_last got %b want 1", l); end
  endtask

  task automatic test_backpressure();
    logic [0:15][31:0] exp;
    logic [511:0] d; logic l;
    exp = '0; exp[0] = 32'h78797A80; exp[15] = 32'h00000018;
    send(32'h78797A00, 1'b1, 3'd3);
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (blk_valid !== 1'b1 || in_ready !== 1'b0 || blk_data !== exp || blk_last !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_hold_c%0d got valid=%b ready=%b last=%b data=%h want 1/0/1 %h",
                 c, blk_valid, in_ready, blk_last, blk_data, exp);
      end
      @(negedge clk);
    end
    get_block(d, l);
    n_cmp++; if (d !== exp) begin n_bad++; $display("FAIL bp_data got %h want %h", d, exp); end
    n_cmp++; if (blk_valid !== 1'b0) begin n_bad++; $display("FAIL bp_single_xfer got %b want 0", blk_valid); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) send(32'h11111111 * 32'(i + 1), 1'b0, 3'd0);
    do_reset();
    check_abc("rst_mid_msg");
    for (int i = 0; i < 16; i++) send(32'h0F0F0000 | 32'(i), 1'b0, 3'd0);
    n_cmp++; if (blk_valid !== 1'b1) begin n_bad++; $display("FAIL full_blk_valid got %b want 1", blk_valid); end
    do_reset();
    n_cmp++; if (blk_valid !== 1'b0 || blk_data !== 512'h0) begin
      n_bad++; $display("FAIL rst_mid_emit got valid=%b data=%h want 0/0", blk_valid, blk_data);
    end
    check_abc("rst_mid_emit");
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_sat_bytes();
    test_56_bytes();
    test_64_bytes();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
